mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter that shares one single-port memory between instruction fetch and data.
// Data has priority, but a waiting fetch is guaranteed a slot after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_d,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       data_wins;

    // Data wins any contest unless the fetch side has already been passed over LIMIT times.
    assign data_wins = d_req & (~if_req | (starve_cnt != LIMIT));

    assign stall_if = if_req & ~if_valid;
    assign stall_d  = d_req & ~d_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        if (data_wins) begin
                            state     <= ACC_D;
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (if_req)
                                starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
                            else
                                starve_cnt <= '0;
                        end else begin
                            state      <= ACC_I;
                            if_gnt     <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            starve_cnt <= '0;
                        end
                    end
                end
                ACC_I: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                ACC_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        d_valid <= 1'b1;
                        // Stores complete without disturbing the last loaded word.
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, priority, store, starvation guard, mid-access reset, stray ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, stall_if, stall_d, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_d(stall_d), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #2;
        d_req = 1'b1; d_addr = 32'h0000_1000;
        step(); step();
        checks++; if ({mem_req, mem_we, busy, if_gnt, d_gnt, if_valid, d_valid} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, busy, if_gnt, d_gnt, if_valid, d_valid}); end
        checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
        @(negedge clk); rst = 1'b1;
        step();
        checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL first_arb: got gnt %b addr %h want 1 00001000", d_gnt, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0; d_req = 1'b0;
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL first_load: got %b %h want 1 12345678", d_valid, d_rdata); end
        step();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        step();
        checks++; if (mem_req !== 1'b1 || if_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_grant: got req %b gnt %b we %b addr %h want 1 1 0 100", mem_req, if_gnt, mem_we, mem_addr); end
        checks++; if (busy !== 1'b1 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_busy: got busy %b stall %b want 1 1", busy, stall_if); end
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0093;
        step();
        checks++; if (mem_req !== 1'b0 || if_valid !== 1'b1 || if_gnt !== 1'b0 || if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL fetch_done: got req %b valid %b gnt %b rdata %h want 0 1 0 00a00093", mem_req, if_valid, if_gnt, if_rdata); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall: got %b want 0", stall_if); end
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        step();
        checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h00A0_0093 || busy !== 1'b0) begin errors++; $display("FAIL fetch_hold: got valid %b rdata %h busy %b want 0 00a00093 0", if_valid, if_rdata, busy); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        step();
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_data: got dg %b ig %b addr %h we %b want 1 0 2000 0", d_gnt, if_gnt, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h1111_2222 || stall_if !== 1'b1) begin errors++; $display("FAIL prio_load: got v %b rdata %h stall_if %b want 1 11112222 1", d_valid, d_rdata, stall_if); end
        d_req = 1'b0; mem_ack = 1'b0;
        step();
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_fetch: got ig %b addr %h we %b want 1 104 0", if_gnt, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        step();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h3333_4444 || d_rdata !== 32'h1111_2222) begin errors++; $display("FAIL prio_fetch_done: got v %b if %h d %h want 1 33334444 11112222", if_valid, if_rdata, d_rdata); end
        if_req = 1'b0; mem_ack = 1'b0;
        step();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2004; d_wdata = 32'hDEAD_BEEF;
        step();
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2004 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_grant: got g %b we %b addr %h wd %h want 1 1 2004 deadbeef", d_gnt, mem_we, mem_addr, mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || d_valid !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL store_wait%0d: got req %b we %b wd %h v %b g %b want 1 1 deadbeef 0 0", i, mem_req, mem_we, mem_wdata, d_valid, d_gnt); end
        end
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h1111_2222 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done: got v %b rdata %h req %b want 1 11112222 0", d_valid, d_rdata, mem_req); end
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b want 0", d_valid); end
    endtask

    task automatic test_starve();
        logic [5:0] exp_data;
        exp_data = 6'b101111;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (d_gnt !== exp_data[i] || if_gnt !== !exp_data[i]) begin errors++; $display("FAIL starve_order%0d: got dg %b ig %b want %b %b", i, d_gnt, if_gnt, exp_data[i], !exp_data[i]); end
            mem_ack = 1'b1; mem_rdata = 32'hC000_0000 + 32'(i);
            step();
            mem_ack = 1'b0;
        end
        checks++; if (d_rdata !== 32'hC000_0005 || if_rdata !== 32'hC000_0004) begin errors++; $display("FAIL starve_data: got d %h if %h want c0000005 c0000004", d_rdata, if_rdata); end
        if_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        step();
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_start: got req %b busy %b want 1 1", mem_req, busy); end
        #3 rst = 1'b0;
        #1;
        checks++; if ({mem_req, mem_we, busy, d_gnt, d_valid} !== 5'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL mid_async: got %b addr %h want 0 0", {mem_req, mem_we, busy, d_gnt, d_valid}, mem_addr); end
        checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got d %h if %h want 0 0", d_rdata, if_rdata); end
        d_req = 1'b0;
        @(negedge clk); rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        checks++; if ({mem_req, busy, d_valid, if_valid, d_gnt, if_gnt} !== 6'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL mid_late_ack: got %b rdata %h want 0 0", {mem_req, busy, d_valid, if_valid, d_gnt, if_gnt}, d_rdata); end
        step();
    endtask

    task automatic test_idle_ack();
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if ({if_valid, d_valid, busy, mem_req} !== 4'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL idle_ack: got %b if %h d %h want 0 0 0", {if_valid, d_valid, busy, mem_req}, if_rdata, d_rdata); end
        d_req = 1'b1; d_addr = 32'h0000_5000;
        step();
        checks++; if (d_gnt !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL idle_then_req: got g %b busy %b want 1 1", d_gnt, busy); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0; d_req = 1'b0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_starve();
        test_reset_mid();
        test_idle_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
